// File: rtl/demux_pkg.sv
// demux_pkg: shared constants and types for the demux_pipe block.
//   DEMUX_WIDTH  default payload width
//   SEL_A/SEL_B  in_select encoding (1 = output A, 0 = output B)
//   COUNT_WIDTH  width of the optional delivery counters (DEMUX_STATS_EN)
//   slot_state_e state of a one-entry output register
package demux_pkg;

  localparam int unsigned DEMUX_WIDTH = 32;
  localparam logic        SEL_A       = 1'b1;
  localparam logic        SEL_B       = 1'b0;
  localparam int unsigned COUNT_WIDTH = 16;

  typedef enum logic {
    StEmpty = 1'b0,
    StFull  = 1'b1
  } slot_state_e;

endpackage

// File: rtl/demux_pipe_if.sv
// demux_pipe_if: handshake bundle for demux_pipe.
//   in_*  producer stream (data, select, valid / ready)
//   a_*   consumer A stream (data, valid / ready)
//   b_*   consumer B stream (data, valid / ready)
//   a_count/b_count delivery counters, present only with DEMUX_STATS_EN
// Modports: master = producer/consumer side, slave = demux_pipe.
interface demux_pipe_if
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
);

  logic [WIDTH-1:0] in_data;
  logic             in_select;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_data;
  logic             a_valid;
  logic             a_ready;
  logic [WIDTH-1:0] b_data;
  logic             b_valid;
  logic             b_ready;
`ifdef DEMUX_STATS_EN
  logic [COUNT_WIDTH-1:0] a_count;
  logic [COUNT_WIDTH-1:0] b_count;
`endif

  modport master (
    output in_data, in_select, in_valid, a_ready, b_ready,
    input  in_ready, a_data, a_valid, b_data, b_valid
`ifdef DEMUX_STATS_EN
    , input a_count, b_count
`endif
  );

  modport slave (
    input  in_data, in_select, in_valid, a_ready, b_ready,
    output in_ready, a_data, a_valid, b_data, b_valid
`ifdef DEMUX_STATS_EN
    , output a_count, b_count
`endif
  );

endinterface

// File: rtl/demux_out_reg.sv
// demux_out_reg: one-entry output buffer (EMPTY/FULL) for one demux leg.
//   clk, rst_n   clock, asynchronous active-low reset
//   load_i       write load_data_i into the buffer this cycle
//   load_data_i  payload to store
//   ready_i      consumer takes data_o this cycle
//   valid_o      buffer holds an unconsumed payload
//   data_o       buffered payload (holds last value after drain)
//   slot_free_o  buffer can accept a load this cycle
//   count_o      saturating handshake count (DEMUX_STATS_EN only)
module demux_out_reg
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o,
  output logic             slot_free_o
`ifdef DEMUX_STATS_EN
  ,
  output logic [COUNT_WIDTH-1:0] count_o
`endif
);

  slot_state_e      state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    // A load wins over a drain: simultaneous drain+load keeps the slot full.
    if (load_i) begin
      state_d = StFull;
      data_d  = load_data_i;
    end else if (state_q == StFull && ready_i) begin
      state_d = StEmpty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign valid_o     = (state_q == StFull);
  assign data_o      = data_q;
  // Free if empty, or if the current entry leaves this cycle.
  assign slot_free_o = (state_q == StEmpty) | ready_i;

`ifdef DEMUX_STATS_EN
  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (valid_o && ready_i && count_q != '1) begin
      count_d = count_q + COUNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
`endif

endmodule

// File: rtl/demux_pipe.sv
// demux_pipe: registered 1-to-2 demultiplexer with one buffered entry per output.
//   clk, rst_n  clock, asynchronous active-low reset
//   bus         demux_pipe_if.slave: producer stream in, consumer streams A and B out
// Optional feature macro: DEMUX_STATS_EN adds saturating a_count/b_count
// delivery counters; without it the counters and their ports do not exist.
module demux_pipe
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = DEMUX_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  demux_pipe_if.slave  bus
);

  logic a_free, b_free;
  logic a_load, b_load;
  logic accept;

  // in_ready only looks at the selected leg, so a stalled B never blocks A.
  assign bus.in_ready = (bus.in_select == SEL_A) ? a_free : b_free;
  assign accept       = bus.in_valid & bus.in_ready;
  assign a_load       = accept & (bus.in_select == SEL_A);
  assign b_load       = accept & (bus.in_select == SEL_B);

  demux_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (a_load),
    .load_data_i (bus.in_data),
    .ready_i     (bus.a_ready),
    .valid_o     (bus.a_valid),
    .data_o      (bus.a_data),
    .slot_free_o (a_free)
`ifdef DEMUX_STATS_EN
    ,
    .count_o     (bus.a_count)
`endif
  );

  demux_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (b_load),
    .load_data_i (bus.in_data),
    .ready_i     (bus.b_ready),
    .valid_o     (bus.b_valid),
    .data_o      (bus.b_data),
    .slot_free_o (b_free)
`ifdef DEMUX_STATS_EN
    ,
    .count_o     (bus.b_count)
`endif
  );

endmodule

// File: tb/tb_demux_pipe.sv
// tb_demux_pipe: scoreboard bench for demux_pipe. The driver pushes each issued
// payload onto the queue of its destination; a negedge monitor pops and compares
// on every output handshake and tracks slot occupancy to check valid/in_ready.
module tb_demux_pipe;
  import demux_pkg::*;

  localparam int unsigned W = DEMUX_WIDTH;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  demux_pipe_if #(.WIDTH(W)) bus ();

  demux_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int hs_a = 0;
  int hs_b = 0;

  logic [W-1:0] exp_a[$];
  logic [W-1:0] exp_b[$];

  // Monitor model state.
  logic         m_a, m_b;
  logic         stall_a, stall_b, in_stall;
  logic [W-1:0] prev_a, prev_b, prev_in_data;
  logic         prev_in_sel;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    logic mr;
    if (!rst_n) begin
      m_a = 1'b0;
      m_b = 1'b0;
      stall_a = 1'b0;
      stall_b = 1'b0;
      in_stall = 1'b0;
      exp_a.delete();
      exp_b.delete();
    end else begin
      mr = bus.in_select ? (!m_a | bus.a_ready) : (!m_b | bus.b_ready);
      chk("a_valid", W'(bus.a_valid), W'(m_a));
      chk("b_valid", W'(bus.b_valid), W'(m_b));
      chk("in_ready", W'(bus.in_ready), W'(mr));
      if (stall_a) chk("a_data_hold", bus.a_data, prev_a);
      if (stall_b) chk("b_data_hold", bus.b_data, prev_b);
      if (in_stall && bus.in_valid) begin
        chk("in_data_hold", bus.in_data, prev_in_data);
        chk("in_select_hold", W'(bus.in_select), W'(prev_in_sel));
      end
      if (bus.a_valid && bus.a_ready) begin
        hs_a++;
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_drain: got %0h expected no payload", bus.a_data);
        end else begin
          chk("a_drain", bus.a_data, exp_a.pop_front());
        end
      end
      if (bus.b_valid && bus.b_ready) begin
        hs_b++;
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_drain: got %0h expected no payload", bus.b_data);
        end else begin
          chk("b_drain", bus.b_data, exp_b.pop_front());
        end
      end
      stall_a      = bus.a_valid & !bus.a_ready;
      stall_b      = bus.b_valid & !bus.b_ready;
      prev_a       = bus.a_data;
      prev_b       = bus.b_data;
      in_stall     = bus.in_valid & !mr;
      prev_in_data = bus.in_data;
      prev_in_sel  = bus.in_select;
      // Occupancy after the coming edge.
      if (bus.in_valid && mr && bus.in_select == SEL_A) m_a = 1'b1;
      else if (bus.a_ready) m_a = 1'b0;
      if (bus.in_valid && mr && bus.in_select == SEL_B) m_b = 1'b1;
      else if (bus.b_ready) m_b = 1'b0;
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Leaves in_valid high; caller drops it or issues the next payload.
  task automatic send(input logic [W-1:0] d, input logic s);
    int n = 0;
    bus.in_data   = d;
    bus.in_select = s;
    bus.in_valid  = 1'b1;
    if (s == SEL_A) exp_a.push_back(d);
    else exp_b.push_back(d);
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: in_ready stayed 0 for payload %0h, required 1", d);
      bus.in_valid = 1'b0;
      if (s == SEL_A) void'(exp_a.pop_back());
      else void'(exp_b.pop_back());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic finish_run();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    finish_run();
  end

  initial begin
    time t0;
    int  h0;
    bus.in_data   = '0;
    bus.in_select = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a_ready   = 1'b0;
    bus.b_ready   = 1'b0;

    // Reset / idle.
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_a_valid", W'(bus.a_valid), '0);
    chk("rst_b_valid", W'(bus.b_valid), '0);
    chk("rst_a_data", bus.a_data, '0);
    chk("rst_b_data", bus.b_data, '0);
    bus.in_select = SEL_A;
    #1 chk("rst_in_ready_a", W'(bus.in_ready), W'(1));
    bus.in_select = SEL_B;
    #1 chk("rst_in_ready_b", W'(bus.in_ready), W'(1));
    cycle();

    // Basic routing.
    send(32'd100, SEL_A);
    bus.in_valid = 1'b0;
    chk("route_a_valid", W'(bus.a_valid), W'(1));
    chk("route_a_data", bus.a_data, 32'd100);
    chk("route_b_idle", W'(bus.b_valid), '0);
    send(32'd10, SEL_B);
    bus.in_valid = 1'b0;
    chk("route_b_data", bus.b_data, 32'd10);
    chk("route_a_keep", bus.a_data, 32'd100);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    cycle();

    // Back-pressure on A.
    bus.a_ready = 1'b0;
    send(32'd100, SEL_A);
    bus.in_data   = 32'd200;
    bus.in_select = SEL_A;
    bus.in_valid  = 1'b1;
    exp_a.push_back(32'd200);
    #1 chk("bp_in_ready_low", W'(bus.in_ready), '0);
    cycle();
    chk("bp_a_data_held", bus.a_data, 32'd100);
    chk("bp_in_ready_still_low", W'(bus.in_ready), '0);
    bus.a_ready = 1'b1;
    #1 chk("bp_in_ready_high", W'(bus.in_ready), W'(1));
    cycle();
    bus.in_valid = 1'b0;
    chk("bp_swap_valid", W'(bus.a_valid), W'(1));
    chk("bp_swap_data", bus.a_data, 32'd200);
    cycle();

    // Independence: A stalled full, B still accepts.
    bus.a_ready = 1'b0;
    bus.b_ready = 1'b0;
    send(32'd77, SEL_A);
    send(32'd55, SEL_B);
    bus.in_valid = 1'b0;
    chk("ind_b_data", bus.b_data, 32'd55);
    chk("ind_a_data", bus.a_data, 32'd77);
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    cycle();

    // Throughput: 8 payloads back-to-back.
    h0 = hs_a;
    t0 = $time;
    for (int i = 0; i < 8; i++) send(W'(1000 + i), SEL_A);
    chk("tp_cycles", W'(int'(($time - t0) / 10)), W'(8));
    bus.in_valid = 1'b0;
    cycle();
    chk("tp_handshakes", W'(hs_a - h0), W'(8));

    // Asynchronous reset with B full.
    bus.b_ready = 1'b0;
    send(32'd33, SEL_B);
    bus.in_valid = 1'b0;
    chk("mid_b_full", W'(bus.b_valid), W'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("async_b_valid", W'(bus.b_valid), '0);
    chk("async_b_data", bus.b_data, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    cycle();
    chk("no_replay_b", W'(bus.b_valid), '0);

`ifdef DEMUX_STATS_EN
    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    send(32'd1, SEL_A);
    send(32'd2, SEL_A);
    send(32'd3, SEL_A);
    send(32'd4, SEL_B);
    send(32'd5, SEL_B);
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("a_count", W'(bus.a_count), W'(3));
    chk("b_count", W'(bus.b_count), W'(2));
    force dut.u_out_a.count_q = 16'hFFFF;
    #1 release dut.u_out_a.count_q;
    send(32'd6, SEL_A);
    bus.in_valid = 1'b0;
    cycle();
    cycle();
    chk("a_count_sat", W'(bus.a_count), W'(16'hFFFF));
    chk("b_count_keep", W'(bus.b_count), W'(2));
`endif

    bus.a_ready = 1'b1;
    bus.b_ready = 1'b1;
    cycle();
    cycle();
    chk("exp_a_empty", W'(exp_a.size()), '0);
    chk("exp_b_empty", W'(exp_b.size()), '0);
    finish_run();
  end

endmodule

// File: doc/demux_pipe.md
Name: demux_pipe

Overview:
- Registered 1-to-2 demultiplexer: the distribution counterpart of the 2:1 result mux.
- Routes one valid/ready input stream to output A or output B according to `in_select`, with one buffered entry per output.
- Used where a single producer (e.g. a writeback or load-result source) feeds two consumers that may stall independently.

Parameters:
- WIDTH, 32, data width of the input and both outputs.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- in_data  input  WIDTH  payload from the producer.
- in_select  input  1  destination: 1 = output A, 0 = output B (same polarity as the result mux).
- in_valid  input  1  producer has a payload.
- in_ready  output  1  block accepts the payload this cycle.
- a_data  output  WIDTH  buffered payload for consumer A.
- a_valid  output  1  a_data holds an unconsumed payload.
- a_ready  input  1  consumer A takes a_data this cycle.
- b_data  output  WIDTH  buffered payload for consumer B.
- b_valid  output  1  b_data holds an unconsumed payload.
- b_ready  input  1  consumer B takes b_data this cycle.
- a_count  output  16  payloads delivered on A (DEMUX_STATS_EN only).
- b_count  output  16  payloads delivered on B (DEMUX_STATS_EN only).

Behaviour:
- Reset (rst_n low, asynchronous):
  - a_valid, b_valid, a_data, b_data, a_count, b_count go to 0.
  - A reset asserted mid-operation discards any buffered payload; nothing is replayed after reset.
- Each output is a one-entry register with two states, EMPTY (valid=0) and FULL (valid=1).
- Ready rule: in_ready = in_select ? (!a_valid | a_ready) : (!b_valid | b_ready).
  - in_ready is combinational.
  - in_ready never depends on the non-selected output.
- Accept: occurs when in_valid & in_ready at a clock edge. The selected output register loads in_data and its valid goes to 1. The other output is untouched.
- Latency: a payload accepted at edge N is visible on x_data/x_valid after edge N (one cycle).
- Drain: when x_valid & x_ready at an edge and there is no load to x in the same cycle, x_valid goes to 0. x_data holds its last value.
- Simultaneous drain and load on the same output: x_valid stays 1 and x_data takes the new payload. Full throughput is one payload per cycle per output.
- Independence: A may drain while B loads, and vice versa. A stall on B never blocks payloads selected for A.
- Producer rule: while in_valid & !in_ready, in_data and in_select must stay stable. The bench flags any violation; the RTL does not check it.
- Outputs obey the same rule: x_data stays stable while x_valid & !x_ready.
- in_valid = 0 causes no state change, regardless of in_select.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- Defined:
  - a_count/b_count increment on each completed output handshake (x_valid & x_ready).
  - Counters saturate at 16'hFFFF; they do not wrap.
  - Both counters reset to 0.
- Undefined:
  - a_count/b_count ports and counter logic are removed entirely.
  - Data behaviour is identical to the defined case.

Decomposition:
- Package demux_pkg holds:
  - DEMUX_WIDTH = 32;
  - SEL_A = 1'b1, SEL_B = 1'b0;
  - COUNT_WIDTH = 16;
  - a two-value state type (EMPTY, FULL) for the output register.
- One sub-module, demux_out_reg, instantiated twice (A and B). It contains:
  - the one-entry buffer, with inputs load, load_data, ready and outputs valid, data, slot_free;
  - the optional saturating counter under DEMUX_STATS_EN.
- Top level contains only the ready steering and the load decode.

Test Plan:
- Reset/idle: hold rst_n=0 for 2 cycles, then release -> a_valid=b_valid=0, a_data=b_data=0, in_ready=1 for either select.
- Basic routing:
  - in_data=32'd100, in_select=1, in_valid=1 for one cycle -> next cycle a_valid=1, a_data=100, b_valid=0.
  - Then in_data=32'd10, in_select=0 -> b_data=10.
- Back-pressure: a_ready=0, send 100 to A, then 200 to A -> in_ready=0 with 200 held on input; a_data stays 100. Raise a_ready -> 100 consumed, 200 loaded in the same edge, a_valid stays 1.
- Independence: A full with a_ready=0, send 55 to B -> in_ready=1, b_data=55 next cycle, a_data unchanged.
- Throughput and reset mid-op:
  - Stream 8 payloads to A with a_ready=1 -> 8 handshakes in 8 consecutive cycles.
  - Assert rst_n=0 while b_valid=1 -> b_valid drops immediately, without waiting for a clock edge.
- Stats (DEMUX_STATS_EN): deliver 3 on A and 2 on B -> a_count=3, b_count=2. Force a_count to 16'hFFFF and deliver one more on A -> a_count stays 16'hFFFF.
